// File: rtl/vme_modport_slave_if.sv
// VME slave-side bus bundle: backplane strobes, address/data and responses.
interface vme_modport_slave_if;
  logic        vme_sysreset_n_i;
  logic        vme_as_n_i;
  logic [1:0]  vme_ds_n_i;
  logic        vme_write_n_i;
  logic [5:0]  vme_am_i;
  logic [31:1] vme_addr_i;
  logic        vme_lword_n_i;
  logic        vme_iack_n_i;
  logic [31:0] vme_data_i;
  logic [31:0] vme_data_o;
  logic        vme_data_oe_o;
  logic        vme_dtack_n_o;
  logic        vme_dtack_oe_o;
  logic        vme_berr_n_o;
  logic        vme_retry_n_o;

  modport slave (
    input  vme_sysreset_n_i, vme_as_n_i, vme_ds_n_i, vme_write_n_i, vme_am_i,
           vme_addr_i, vme_lword_n_i, vme_iack_n_i, vme_data_i,
    output vme_data_o, vme_data_oe_o, vme_dtack_n_o, vme_dtack_oe_o,
           vme_berr_n_o, vme_retry_n_o
  );

  modport master (
    output vme_sysreset_n_i, vme_as_n_i, vme_ds_n_i, vme_write_n_i, vme_am_i,
           vme_addr_i, vme_lword_n_i, vme_iack_n_i, vme_data_i,
    input  vme_data_o, vme_data_oe_o, vme_dtack_n_o, vme_dtack_oe_o,
           vme_berr_n_o, vme_retry_n_o
  );
endinterface

// File: rtl/vme_modport_slave.sv
// VME64x A24/A32 D32 single-cycle slave terminating into a 256 x 32 register file.
module vme_modport_slave #(
  parameter logic [21:0] g_base_addr   = 22'h000001,
  parameter int unsigned g_sync_stages = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  vme_modport_slave_if.slave vme
);

  localparam int unsigned LAST = g_sync_stages - 1;

  typedef enum logic [2:0] {IDLE, DECODE, ACCESS, ACK, WAIT_END} state_t;

  state_t      state_q, state_d;
  logic [4:0]  sync_q [g_sync_stages];
  logic        as_s, write_s, sysreset_s;
  logic [1:0]  ds_s;
  logic [31:1] addr_q;
  logic [5:0]  am_q;
  logic        lword_q, rd_q, iack_q, err_q;
  logic [1:0]  ds_lat_q;
  logic [31:0] mem [256];
  logic        am_a32, am_a24, addr_hit, hit, d32, err_d;
  logic [7:0]  idx;

  assign {as_s, ds_s, write_s, sysreset_s} = sync_q[LAST];
  assign vme.vme_retry_n_o = 1'b1;

  // Synchronize the asynchronous strobes, WRITE and SYSRESET into clk_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < g_sync_stages; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {vme.vme_as_n_i, vme.vme_ds_n_i, vme.vme_write_n_i, vme.vme_sysreset_n_i};
      for (int unsigned i = 1; i < g_sync_stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Cycle decode from the attributes latched at AS fall
  always_comb begin
    am_a32   = (am_q == 6'h09) || (am_q == 6'h0D);
    am_a24   = (am_q == 6'h39) || (am_q == 6'h3D);
    addr_hit = am_a32 ? (addr_q[31:10] == g_base_addr)
                      : (addr_q[23:10] == g_base_addr[13:0]);
    hit      = (am_a32 || am_a24) && addr_hit && iack_q;
    d32      = !lword_q && (ds_s == 2'b00) && !addr_q[1];
    idx      = addr_q[9:2];
    err_d    = (state_q == DECODE) ? (hit && !d32) : err_q;
  end

  // FSM state register; SYSRESET acts as a synchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            state_q <= IDLE;
    else if (!sysreset_s) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // Any DS low starts decode so that partial-width cycles can be answered with BERR
      IDLE:     if (!as_s && (ds_s != 2'b11)) state_d = DECODE;
      DECODE:   if (hit && d32)   state_d = ACCESS;
                else if (hit)     state_d = ACK;
                else if (as_s)    state_d = IDLE;
      ACCESS:   state_d = ACK;
      // Leave ACK once AS rises or a strobe that was asserted at decode is released
      ACK:      if (as_s || ((ds_s & ~ds_lat_q) != 2'b00)) state_d = WAIT_END;
      WAIT_END: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Latched cycle attributes, read data path and registered bus responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || !sysreset_s) begin
      addr_q         <= '0;
      am_q           <= '0;
      lword_q        <= 1'b1;
      rd_q           <= 1'b1;
      iack_q         <= 1'b0;
      err_q          <= 1'b0;
      ds_lat_q       <= '1;
      vme.vme_data_o     <= '0;
      vme.vme_data_oe_o  <= 1'b0;
      vme.vme_dtack_n_o  <= 1'b1;
      vme.vme_dtack_oe_o <= 1'b0;
      vme.vme_berr_n_o   <= 1'b1;
    end else begin
      if (state_q == IDLE && !as_s) begin
        addr_q  <= vme.vme_addr_i;
        am_q    <= vme.vme_am_i;
        lword_q <= vme.vme_lword_n_i;
        rd_q    <= write_s;
        iack_q  <= vme.vme_iack_n_i;
      end
      if (state_q == DECODE) ds_lat_q <= ds_s;
      err_q <= err_d;
      // Read word is placed on the bus entering ACCESS, a cycle ahead of DTACK
      if (state_q == DECODE && state_d == ACCESS && rd_q) begin
        vme.vme_data_o    <= mem[idx];
        vme.vme_data_oe_o <= 1'b1;
      end else if (state_d == IDLE) begin
        vme.vme_data_oe_o <= 1'b0;
      end
      vme.vme_dtack_oe_o <= !err_d && (state_d == ACK || state_d == WAIT_END);
      vme.vme_dtack_n_o  <= !(!err_d && state_d == ACK);
      vme.vme_berr_n_o   <= !(err_d && (state_d == ACK || state_d == WAIT_END));
    end
  end

  // Register file write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (state_q == ACCESS && !rd_q) mem[idx] <= vme.vme_data_i;
  end

endmodule

// File: tb/tb_vme_modport_slave.sv
// Directed bench for vme_modport_slave with a read-data scoreboard.
module tb_vme_modport_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  vme_modport_slave_if vme();

  vme_modport_slave #(.g_base_addr(22'h000001), .g_sync_stages(2)) dut (
    .clk_i(clk), .rst_i(rst), .vme(vme)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = DTACK expected, 1 = BERR expected, 2 = no response, 3 = reset pulsed in ACK
  task automatic vme_cycle(input logic [31:0] a, input logic [5:0] am, input logic wr,
                           input logic [31:0] wd, input logic [1:0] ds, input logic lw,
                           input int kind, input string tag);
    int cnt;
    logic seen, other, pre_ok;
    logic [31:0] prev, expd;
    @(negedge clk); #2;
    vme.vme_addr_i    = a[31:1];
    vme.vme_am_i      = am;
    vme.vme_write_n_i = !wr;
    vme.vme_lword_n_i = lw;
    vme.vme_data_i    = wd;
    expd = model[a[9:2]];
    if (kind == 0 && !wr) exp_q.push_back(expd);
    if (kind == 0 && wr)  model[a[9:2]] = wd;
    @(negedge clk); #2 vme.vme_as_n_i = 1'b0;
    @(negedge clk); #2 vme.vme_ds_n_i = ds;
    cnt = 0; seen = 1'b0; other = 1'b0; prev = 'x;
    if (kind == 0 || kind == 3) begin
      while (cnt < 20 && !seen) begin
        prev = vme.vme_data_o;
        @(negedge clk); cnt++;
        if (vme.vme_dtack_n_o === 1'b0) seen = 1'b1;
        if (vme.vme_berr_n_o === 1'b0) other = 1'b1;
      end
      chk({tag, " dtack_latency"}, cnt, 5);
      chk({tag, " no_berr"}, other, 1'b0);
      chk({tag, " dtack_oe"}, vme.vme_dtack_oe_o, 1'b1);
      if (kind == 0 && !wr) begin
        expd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        pre_ok = (prev === expd);
        chk({tag, " rd_data"}, vme.vme_data_o, expd);
        chk({tag, " rd_data_before_dtack"}, pre_ok, 1'b1);
        chk({tag, " data_oe"}, vme.vme_data_oe_o, 1'b1);
      end
      if (kind == 3) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst_dtack_oe"}, vme.vme_dtack_oe_o, 1'b0);
        chk({tag, " rst_data_oe"}, vme.vme_data_oe_o, 1'b0);
        chk({tag, " rst_dtack_n"}, vme.vme_dtack_n_o, 1'b1);
        vme.vme_as_n_i = 1'b1; vme.vme_ds_n_i = 2'b11;
        @(negedge clk); #2 rst = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        #2 vme.vme_as_n_i = 1'b1; vme.vme_ds_n_i = 2'b11;
        cnt = 0; seen = 1'b0;
        while (cnt < 20 && !seen) begin
          @(negedge clk); cnt++;
          if (vme.vme_dtack_n_o === 1'b1) seen = 1'b1;
        end
        chk({tag, " release_latency"}, cnt, 3);
        chk({tag, " dtack_oe_wait_end"}, vme.vme_dtack_oe_o, 1'b1);
        @(negedge clk);
        chk({tag, " dtack_oe_off"}, vme.vme_dtack_oe_o, 1'b0);
        chk({tag, " data_oe_off"}, vme.vme_data_oe_o, 1'b0);
        chk({tag, " berr_idle"}, vme.vme_berr_n_o, 1'b1);
      end
    end else if (kind == 1) begin
      while (cnt < 20 && !seen) begin
        @(negedge clk); cnt++;
        if (vme.vme_berr_n_o === 1'b0) seen = 1'b1;
        if (vme.vme_dtack_n_o === 1'b0) other = 1'b1;
      end
      chk({tag, " berr_low"}, seen, 1'b1);
      #2 vme.vme_as_n_i = 1'b1; vme.vme_ds_n_i = 2'b11;
      cnt = 0; seen = 1'b0;
      while (cnt < 20 && !seen) begin
        @(negedge clk); cnt++;
        if (vme.vme_berr_n_o === 1'b1) seen = 1'b1;
        if (vme.vme_dtack_n_o === 1'b0) other = 1'b1;
      end
      chk({tag, " berr_released"}, seen, 1'b1);
      chk({tag, " dtack_never_low"}, other, 1'b0);
    end else begin
      while (cnt < 1000) begin
        @(negedge clk); cnt++;
        if (vme.vme_dtack_n_o !== 1'b1 || vme.vme_berr_n_o !== 1'b1 ||
            vme.vme_dtack_oe_o !== 1'b0) other = 1'b1;
      end
      chk({tag, " no_response"}, other, 1'b0);
      #2 vme.vme_as_n_i = 1'b1; vme.vme_ds_n_i = 2'b11;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    vme.vme_sysreset_n_i = 1'b1;
    vme.vme_as_n_i       = 1'b1;
    vme.vme_ds_n_i       = 2'b11;
    vme.vme_write_n_i    = 1'b1;
    vme.vme_am_i         = 6'h09;
    vme.vme_addr_i       = '0;
    vme.vme_lword_n_i    = 1'b0;
    vme.vme_iack_n_i     = 1'b1;
    vme.vme_data_i       = '0;
    for (int unsigned i = 0; i < 256; i++) model[i] = 32'hx;
    repeat (3) @(negedge clk);
    chk("reset data_o", vme.vme_data_o, 32'h0);
    chk("reset data_oe", vme.vme_data_oe_o, 1'b0);
    chk("reset dtack_n", vme.vme_dtack_n_o, 1'b1);
    chk("reset dtack_oe", vme.vme_dtack_oe_o, 1'b0);
    chk("reset berr_n", vme.vme_berr_n_o, 1'b1);
    chk("reset retry_n", vme.vme_retry_n_o, 1'b1);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    vme_cycle(32'h0000_0410, 6'h09, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 0, "a32_wr");
    vme_cycle(32'h0000_0410, 6'h09, 1'b0, 32'h0,         2'b00, 1'b0, 0, "a32_rd");
    vme_cycle(32'h0000_0404, 6'h39, 1'b1, 32'h1234_5678, 2'b00, 1'b0, 0, "a24_wr");
    vme_cycle(32'h0000_0404, 6'h3D, 1'b0, 32'h0,         2'b00, 1'b0, 0, "a24_rd");
    vme_cycle(32'h0080_0000, 6'h09, 1'b0, 32'h0,         2'b00, 1'b0, 2, "addr_miss");
    vme_cycle(32'h0000_0410, 6'h29, 1'b0, 32'h0,         2'b00, 1'b0, 2, "am_miss");
    vme_cycle(32'h0000_0410, 6'h0D, 1'b0, 32'h0,         2'b00, 1'b0, 0, "rd_after_miss");
    vme_cycle(32'h0000_0410, 6'h09, 1'b0, 32'h0,         2'b01, 1'b1, 1, "ds1_lword");
    vme_cycle(32'h0000_0412, 6'h09, 1'b1, 32'h5555_AAAA, 2'b00, 1'b0, 1, "a1_set");
    vme_cycle(32'h0000_0410, 6'h09, 1'b0, 32'h0,         2'b00, 1'b0, 3, "rst_in_ack");
    vme_cycle(32'h0000_0410, 6'h09, 1'b0, 32'h0,         2'b00, 1'b0, 0, "rd_after_rst");

    for (int unsigned i = 0; i < 256; i++)
      vme_cycle(32'h0000_0400 + 32'(4 * i), 6'h09, 1'b1, 32'hA5000000 ^ (32'(i) * 32'h0101_0103),
                2'b00, 1'b0, 0, "idx_wr");
    for (int unsigned i = 0; i < 256; i++)
      vme_cycle(32'h0000_0400 + 32'(4 * i), 6'h09, 1'b0, 32'h0, 2'b00, 1'b0, 0, "idx_rd");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
